// File: rtl/sar_cdac_ctrl_if.sv
// Handshake/bus bundle between the SAR controller and its surroundings.
//   master : controller side (drives plate code, strobes, status, result)
//   slave  : environment side (drives START request and comparator decision)
// Signals:
//   START   - conversion request (slave -> master)
//   COMP    - comparator decision, 1 = input above DAC level (slave -> master)
//   CB_P    - bottom-plate drive code, MSB drives MSB group (master -> slave)
//   SAMPLE  - top-plate sample switch enable (master -> slave)
//   COMP_EN - comparator strobe (master -> slave)
//   BUSY    - sampling or converting (master -> slave)
//   DONE    - one-cycle pulse when DOUT updates (master -> slave)
//   DOUT    - last completed conversion result (master -> slave)
interface sar_cdac_ctrl_if #(
    parameter int unsigned NBITS = 10
);
    logic             START;
    logic             COMP;
    logic [NBITS-1:0] CB_P;
    logic             SAMPLE;
    logic             COMP_EN;
    logic             BUSY;
    logic             DONE;
    logic [NBITS-1:0] DOUT;

    modport master (
        input  START, COMP,
        output CB_P, SAMPLE, COMP_EN, BUSY, DONE, DOUT
    );

    modport slave (
        output START, COMP,
        input  CB_P, SAMPLE, COMP_EN, BUSY, DONE, DOUT
    );
endinterface

// File: rtl/sar_cdac_ctrl.sv
// Successive-approximation controller for a MOM capacitor DAC array.
// Runs the sample phase, then one TRIAL/DECIDE cycle pair per bit (MSB first),
// strobing the comparator on the shared top-plate node, and publishes the code.
// Ports:
//   CLK - rising-edge clock
//   RST - synchronous active-high reset
//   bus - sar_cdac_ctrl_if master modport (START/COMP in; CB_P, SAMPLE,
//         COMP_EN, BUSY, DONE, DOUT out)
// All outputs are registered and decoded from the next state, so they are
// glitch-free and line up with the state they describe.
module sar_cdac_ctrl #(
    parameter int unsigned NBITS         = 10,
    parameter int unsigned SAMPLE_CYCLES = 4
) (
    input  logic           CLK,
    input  logic           RST,
    sar_cdac_ctrl_if.master bus
);
    localparam int unsigned KW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned CW = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [NBITS-1:0] BitOne = NBITS'(1);

    typedef enum logic [2:0] {
        StIdle,
        StSamp,
        StTrial,
        StDecide,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [NBITS-1:0] w_q, w_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic [NBITS-1:0] cb_p_q, cb_p_d;
    logic             sample_q, sample_d;
    logic             comp_en_q, comp_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        w_d     = w_q;
        dout_d  = dout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.START) begin
                    state_d = StSamp;
                    cnt_d   = CW'(SAMPLE_CYCLES - 1);
                end
            end
            StSamp: begin
                if (cnt_q == '0) begin
                    state_d = StTrial;
                    k_d     = KW'(NBITS - 1);
                    w_d     = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StTrial: begin
                state_d = StDecide;
            end
            StDecide: begin
                // Comparator is sampled at the edge closing the strobe window.
                w_d[k_q] = bus.COMP;
                if (k_q == '0) begin
                    state_d = StDone;
                    dout_d  = w_d;
                end else begin
                    k_d     = k_q - 1'b1;
                    state_d = StTrial;
                end
            end
            StDone: begin
                if (bus.START) begin
                    state_d = StSamp;
                    cnt_d   = CW'(SAMPLE_CYCLES - 1);
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Output decode from the next state keeps outputs aligned with state.
        cb_p_d    = '0;
        if (state_d == StTrial || state_d == StDecide) begin
            cb_p_d = w_d | (BitOne << k_d);
        end
        sample_d  = (state_d == StSamp);
        comp_en_d = (state_d == StDecide);
        busy_d    = (state_d == StSamp) || (state_d == StTrial) || (state_d == StDecide);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            k_q       <= '0;
            w_q       <= '0;
            dout_q    <= '0;
            cb_p_q    <= '0;
            sample_q  <= 1'b0;
            comp_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            w_q       <= w_d;
            dout_q    <= dout_d;
            cb_p_q    <= cb_p_d;
            sample_q  <= sample_d;
            comp_en_q <= comp_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.CB_P    = cb_p_q;
    assign bus.SAMPLE  = sample_q;
    assign bus.COMP_EN = comp_en_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.DOUT    = dout_q;
endmodule

// File: tb/tb_sar_cdac_ctrl.sv
// Directed self-checking bench for sar_cdac_ctrl (NBITS=10, SAMPLE_CYCLES=4).
module tb_sar_cdac_ctrl;
    localparam int unsigned NB = 10;
    localparam int unsigned SC = 4;

    logic CLK = 1'b0;
    logic RST;

    sar_cdac_ctrl_if #(.NBITS(NB)) bus ();

    sar_cdac_ctrl #(
        .NBITS        (NB),
        .SAMPLE_CYCLES(SC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Comparator model: 0 = ideal against target, 1 = stuck high, 2 = stuck low.
    int          mode;
    logic [9:0]  target;
    assign bus.COMP = (mode == 0) ? (target >= bus.CB_P) : (mode == 1);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Per-conversion observations.
    int         lat, n_samp, n_cen, n_busy, n_ovl, n_trial;
    logic [9:0] trial [10];

    // Raise START for one edge, then observe cycle t0+c at each falling edge
    // until DONE appears (bounded).
    task automatic run_conv();
        lat = -1; n_samp = 0; n_cen = 0; n_busy = 0; n_ovl = 0; n_trial = 0;
        @(negedge CLK);
        bus.START = 1'b1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge CLK);
            if (c == 0) bus.START = 1'b0;
            if (bus.SAMPLE) n_samp++;
            if (bus.COMP_EN) n_cen++;
            if (bus.SAMPLE && bus.COMP_EN) n_ovl++;
            if (bus.BUSY) n_busy++;
            if (bus.BUSY && !bus.SAMPLE && !bus.COMP_EN && n_trial < 10) begin
                trial[n_trial] = bus.CB_P;
                n_trial++;
            end
            if (bus.DONE) lat = c;
        end
    endtask

    initial begin
        int n_done;
        int dpos [3];
        logic samp25, busy25;

        RST       = 1'b1;
        bus.START = 1'b0;
        mode      = 0;
        target    = 10'h2A5;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Reset state
        check("rst_cb_p",    32'(bus.CB_P),    32'h0);
        check("rst_sample",  32'(bus.SAMPLE),  32'h0);
        check("rst_comp_en", 32'(bus.COMP_EN), 32'h0);
        check("rst_busy",    32'(bus.BUSY),    32'h0);
        check("rst_done",    32'(bus.DONE),    32'h0);
        check("rst_dout",    32'(bus.DOUT),    32'h0);

        // Ideal comparator, target 0x2A5
        run_conv();
        check("ideal_latency", 32'(lat), 32'd24);
        check("ideal_trial0",  32'(trial[0]), 32'h200);
        check("ideal_trial1",  32'(trial[1]), 32'h300);
        check("ideal_trial2",  32'(trial[2]), 32'h280);
        check("ideal_dout",    32'(bus.DOUT), 32'h2A5);
        check("done_busy",     32'(bus.BUSY), 32'h0);
        check("done_cb_p",     32'(bus.CB_P), 32'h0);
        check("n_sample",      32'(n_samp), 32'd4);
        check("n_comp_en",     32'(n_cen),  32'd10);
        check("n_busy",        32'(n_busy), 32'd24);
        check("sample_cen_ovl", 32'(n_ovl), 32'd0);
        @(negedge CLK);
        check("done_pulse_1cyc", 32'(bus.DONE), 32'h0);
        repeat (5) @(negedge CLK);
        check("dout_hold",  32'(bus.DOUT), 32'h2A5);
        check("idle_busy",  32'(bus.BUSY), 32'h0);

        // Stuck comparators
        mode = 1;
        run_conv();
        check("stuck1_dout", 32'(bus.DOUT), 32'h3FF);
        mode = 2;
        run_conv();
        check("stuck0_dout",      32'(bus.DOUT),  32'h000);
        check("stuck0_last_trial", 32'(trial[9]), 32'h001);
        check("stuck0_latency",   32'(lat), 32'd24);

        // Reset mid-conversion during bit-5 DECIDE (cycle t0+13)
        mode   = 0;
        target = 10'h155;
        run_conv();
        check("prior_dout", 32'(bus.DOUT), 32'h155);
        target = 10'h2A5;
        @(negedge CLK);
        bus.START = 1'b1;
        for (int c = 0; c <= 13; c++) begin
            @(negedge CLK);
            if (c == 0) bus.START = 1'b0;
        end
        check("bit5_decide_cen",  32'(bus.COMP_EN), 32'h1);
        check("bit5_decide_cb_p", 32'(bus.CB_P),    32'h2A0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_cb_p",    32'(bus.CB_P),    32'h0);
        check("midrst_sample",  32'(bus.SAMPLE),  32'h0);
        check("midrst_comp_en", 32'(bus.COMP_EN), 32'h0);
        check("midrst_busy",    32'(bus.BUSY),    32'h0);
        check("midrst_done",    32'(bus.DONE),    32'h0);
        check("midrst_dout",    32'(bus.DOUT),    32'h0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (bus.DONE || bus.BUSY) n_done++;
        end
        check("midrst_no_activity", 32'(n_done), 32'd0);
        target = 10'h0F0;
        run_conv();
        check("post_rst_latency", 32'(lat), 32'd24);
        check("post_rst_dout",    32'(bus.DOUT), 32'h0F0);

        // Handshake: START held high continuously
        target = 10'h2A5;
        n_done = 0;
        samp25 = 1'b0;
        busy25 = 1'b0;
        dpos   = '{default: -1};
        @(negedge CLK);
        bus.START = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge CLK);
            if (bus.DONE) begin
                if (n_done < 3) dpos[n_done] = c;
                n_done++;
            end
            if (c == 25) begin
                samp25 = bus.SAMPLE;
                busy25 = bus.BUSY;
            end
        end
        bus.START = 1'b0;
        check("hs_n_done",   32'(n_done),  32'd3);
        check("hs_done0",    32'(dpos[0]), 32'd24);
        check("hs_done1",    32'(dpos[1]), 32'd49);
        check("hs_done2",    32'(dpos[2]), 32'd74);
        check("hs_resample", 32'(samp25),  32'h1);
        check("hs_rebusy",   32'(busy25),  32'h1);
        check("hs_dout",     32'(bus.DOUT), 32'h2A5);
        repeat (30) @(negedge CLK);
        check("hs_idle", 32'(bus.BUSY), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
